led_slice_scheduler: RTL and testbench

Sequences the TLC-style LED driver shift engine against the rotating platter. It turns encoder home/tick pulses into angular slice events and runs the one-time control-latch load after reset. For each slice it swaps the grayscale double buffer and starts a grayscale shift, then asks the HDMI fill side for the next slice. It sits between the encoder inputs, the HDMI slice writer and the serial shift engine that drives SDO/SCLK/LAT.

---
 rtl/led_slice_scheduler_if.sv | 22 ++
 rtl/led_slice_scheduler.sv | 202 ++++++++++++++++++++
 tb/tb_led_slice_scheduler.sv | 333 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/led_slice_scheduler_if.sv
// rtl/led_slice_scheduler_if.sv - shift-engine and slice-fill handshake bundle for led_slice_scheduler
interface led_slice_scheduler_if #(
    parameter int SLICE_W = 7
);
    logic               ctrl_start;
    logic               gs_start;
    logic               buf_sel;
    logic               shift_done;
    logic               fill_req;
    logic [SLICE_W-1:0] fill_slice;
    logic               fill_done;

    modport master (
        output ctrl_start, gs_start, buf_sel, fill_req, fill_slice,
        input  shift_done, fill_done
    );

    modport slave (
        input  ctrl_start, gs_start, buf_sel, fill_req, fill_slice,
        output shift_done, fill_done
    );
endinterface

// File: rtl/led_slice_scheduler.sv
// rtl/led_slice_scheduler.sv - encoder-locked slice sequencer for the LED shift engine
// Optional statistics counters: LED_SLICE_SCHED_STATS_EN
module led_slice_scheduler #(
    parameter int NUM_SLICES      = 128,
    parameter int TICKS_PER_SLICE = 3,
    parameter int SLICE_W         = 7
) (
    input  logic                  TESTCLK,
    input  logic                  Reset,
    input  logic                  enc_home,
    input  logic                  enc_tick,
    led_slice_scheduler_if.master bus,
    output logic [SLICE_W-1:0]    slice_idx,
    output logic [15:0]           overrun_cnt,
    output logic [15:0]           underrun_cnt,
    output logic [3:0]            state_dbg
);

    localparam logic [3:0] S_RESET = 4'd0;
    localparam logic [3:0] S_INIT  = 4'd1;
    localparam logic [3:0] S_WAIT  = 4'd2;
    localparam logic [3:0] S_IDLE  = 4'd3;
    localparam logic [3:0] S_START = 4'd4;
    localparam logic [3:0] S_SHIFT = 4'd5;

    localparam int TW = (TICKS_PER_SLICE > 1) ? $clog2(TICKS_PER_SLICE) : 1;
    localparam logic [TW-1:0]      TICK_LAST  = TW'(TICKS_PER_SLICE - 1);
    localparam logic [SLICE_W-1:0] SLICE_LAST = SLICE_W'(NUM_SLICES - 1);

    function automatic logic [SLICE_W-1:0] next_slice(input logic [SLICE_W-1:0] s);
        return (s == SLICE_LAST) ? '0 : s + 1'b1;
    endfunction

    logic [2:0]         home_sync_q, tick_sync_q;
    logic               home_ev_q, tick_ev_q;
    logic [3:0]         state_q, state_d;
    logic [TW-1:0]      tick_cnt_q, tick_cnt_d;
    logic [SLICE_W-1:0] target_q, target_d;
    logic [SLICE_W-1:0] slice_idx_q, slice_idx_d;
    logic [SLICE_W-1:0] fill_slice_q, fill_slice_d;
    logic               buf_sel_q, buf_sel_d;
    logic               fill_pend_q, fill_pend_d;
    logic               fill_ready_q, fill_ready_d;
    logic               ctrl_start_q, ctrl_start_d;
    logic               gs_start_q, gs_start_d;
    logic               fill_req_q, fill_req_d;
    logic               slice_due;
    logic               fill_ready_now;
    logic               tracking;

    // Third sync stage doubles as the edge detector's history bit.
    always_ff @(posedge TESTCLK) begin
        if (Reset) begin
            home_sync_q <= '0;
            tick_sync_q <= '0;
            home_ev_q   <= 1'b0;
            tick_ev_q   <= 1'b0;
        end else begin
            home_sync_q <= {home_sync_q[1:0], enc_home};
            tick_sync_q <= {tick_sync_q[1:0], enc_tick};
            home_ev_q   <= home_sync_q[1] & ~home_sync_q[2];
            tick_ev_q   <= tick_sync_q[1] & ~tick_sync_q[2];
        end
    end

    assign tracking       = (state_q != S_RESET) && (state_q != S_INIT);
    assign fill_ready_now = fill_ready_q | (bus.fill_done & fill_pend_q);

    always_comb begin
        state_d      = state_q;
        tick_cnt_d   = tick_cnt_q;
        target_d     = target_q;
        slice_idx_d  = slice_idx_q;
        fill_slice_d = fill_slice_q;
        buf_sel_d    = buf_sel_q;
        fill_pend_d  = fill_pend_q;
        fill_ready_d = fill_ready_q;
        ctrl_start_d = 1'b0;
        gs_start_d   = 1'b0;
        fill_req_d   = 1'b0;
        slice_due    = 1'b0;

        if (tracking) begin
            if (home_ev_q) begin
                tick_cnt_d = '0;
                target_d   = '0;
                slice_due  = 1'b1;
            end else if (tick_ev_q && (state_q != S_WAIT)) begin
                if (tick_cnt_q == TICK_LAST) begin
                    tick_cnt_d = '0;
                    target_d   = next_slice(target_q);
                    slice_due  = 1'b1;
                end else begin
                    tick_cnt_d = tick_cnt_q + 1'b1;
                end
            end
        end

        if (bus.fill_done && fill_pend_q) begin
            fill_ready_d = 1'b1;
            fill_pend_d  = 1'b0;
        end

        case (state_q)
            S_RESET: begin
                state_d      = S_INIT;
                ctrl_start_d = 1'b1;
            end
            S_INIT: begin
                if (bus.shift_done) begin
                    state_d      = S_WAIT;
                    fill_req_d   = 1'b1;
                    fill_slice_d = '0;
                    fill_pend_d  = 1'b1;
                end
            end
            S_WAIT, S_IDLE: begin
                if (slice_due) begin
                    state_d = S_START;
                    // Without a filled buffer the old slice is simply shown again.
                    if (fill_ready_now) begin
                        buf_sel_d    = ~buf_sel_q;
                        slice_idx_d  = target_d;
                        fill_ready_d = 1'b0;
                        fill_req_d   = 1'b1;
                        fill_slice_d = next_slice(target_d);
                        fill_pend_d  = 1'b1;
                    end
                end
            end
            S_START: begin
                gs_start_d = 1'b1;
                state_d    = S_SHIFT;
            end
            S_SHIFT: begin
                if (bus.shift_done) state_d = S_IDLE;
            end
            default: state_d = S_RESET;
        endcase
    end

    always_ff @(posedge TESTCLK) begin
        if (Reset) begin
            state_q      <= S_RESET;
            tick_cnt_q   <= '0;
            target_q     <= '0;
            slice_idx_q  <= '0;
            fill_slice_q <= '0;
            buf_sel_q    <= 1'b0;
            fill_pend_q  <= 1'b0;
            fill_ready_q <= 1'b0;
            ctrl_start_q <= 1'b0;
            gs_start_q   <= 1'b0;
            fill_req_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            tick_cnt_q   <= tick_cnt_d;
            target_q     <= target_d;
            slice_idx_q  <= slice_idx_d;
            fill_slice_q <= fill_slice_d;
            buf_sel_q    <= buf_sel_d;
            fill_pend_q  <= fill_pend_d;
            fill_ready_q <= fill_ready_d;
            ctrl_start_q <= ctrl_start_d;
            gs_start_q   <= gs_start_d;
            fill_req_q   <= fill_req_d;
        end
    end

`ifdef LED_SLICE_SCHED_STATS_EN
    logic        overrun_inc, underrun_inc;
    logic [15:0] overrun_q, underrun_q;

    assign overrun_inc  = slice_due && ((state_q == S_START) || (state_q == S_SHIFT));
    assign underrun_inc = slice_due && ((state_q == S_IDLE) || (state_q == S_WAIT)) && !fill_ready_now;

    always_ff @(posedge TESTCLK) begin
        if (Reset) begin
            overrun_q  <= '0;
            underrun_q <= '0;
        end else begin
            if (overrun_inc && (overrun_q != 16'hFFFF))   overrun_q  <= overrun_q + 16'd1;
            if (underrun_inc && (underrun_q != 16'hFFFF)) underrun_q <= underrun_q + 16'd1;
        end
    end

    assign overrun_cnt  = overrun_q;
    assign underrun_cnt = underrun_q;
`else
    assign overrun_cnt  = '0;
    assign underrun_cnt = '0;
`endif

    assign bus.ctrl_start = ctrl_start_q;
    assign bus.gs_start   = gs_start_q;
    assign bus.buf_sel    = buf_sel_q;
    assign bus.fill_req   = fill_req_q;
    assign bus.fill_slice = fill_slice_q;
    assign slice_idx      = slice_idx_q;
    assign state_dbg      = state_q;

endmodule

// File: tb/tb_led_slice_scheduler.sv
// tb/tb_led_slice_scheduler.sv - self-checking bench for led_slice_scheduler
module tb_led_slice_scheduler;

    localparam int N = 128;
    localparam int T = 3;

    logic       TESTCLK = 1'b0;
    logic       Reset   = 1'b1;
    logic       enc_home = 1'b0;
    logic       enc_tick = 1'b0;
    logic [6:0] slice_idx;
    logic [15:0] overrun_cnt, underrun_cnt;
    logic [3:0] state_dbg;

    led_slice_scheduler_if #(.SLICE_W(7)) bus ();

    led_slice_scheduler #(.NUM_SLICES(N), .TICKS_PER_SLICE(T), .SLICE_W(7)) dut (
        .TESTCLK      (TESTCLK),
        .Reset        (Reset),
        .enc_home     (enc_home),
        .enc_tick     (enc_tick),
        .bus          (bus),
        .slice_idx    (slice_idx),
        .overrun_cnt  (overrun_cnt),
        .underrun_cnt (underrun_cnt),
        .state_dbg    (state_dbg)
    );

    always #5 TESTCLK = ~TESTCLK;

    int n_checks = 0;
    int n_err    = 0;

    // responder / monitor controls
    bit sh_en = 1'b0;
    bit fl_en = 1'b0;
    int sh_delay = 20;
    int spur_req = 0;
    int spur_ack = 0;
    bit sh_pend, fl_pend;
    int sh_cnt, fl_cnt;
    int n_ctrl = 0, n_gs = 0, n_wide = 0;
    logic ctrl_prev = 1'b0, gs_prev = 1'b0, freq_prev = 1'b0;

    // behavioural slice model
    int m_target, m_tick, m_slice, m_buf, m_fs, m_under, m_over, m_gs;
    bit m_ready, m_pend, m_busy;

    typedef struct {
        int op;      // 0 tick, 1 home, 2 home+tick together
        bit f;
        bit s;
        int slice;
        int bsel;
        int under;
        int over;
        int fs;
    } vec_t;
    vec_t tbl[22];

    always @(negedge TESTCLK) begin
        bus.shift_done = 1'b0;
        bus.fill_done  = 1'b0;
        if (Reset) begin
            sh_pend = 1'b0;
            fl_pend = 1'b0;
        end else begin
            if (bus.ctrl_start) n_ctrl++;
            if (bus.gs_start) n_gs++;
            if ((bus.ctrl_start && ctrl_prev) || (bus.gs_start && gs_prev) || (bus.fill_req && freq_prev))
                n_wide++;
            if (bus.ctrl_start || bus.gs_start) begin
                sh_pend = 1'b1;
                sh_cnt  = 0;
            end else if (sh_pend && sh_en) begin
                sh_cnt++;
                if (sh_cnt >= sh_delay) begin
                    bus.shift_done = 1'b1;
                    sh_pend = 1'b0;
                end
            end
            if (bus.fill_req) begin
                fl_pend = 1'b1;
                fl_cnt  = 0;
            end else if (fl_pend && fl_en) begin
                fl_cnt++;
                if (fl_cnt >= 3) begin
                    bus.fill_done = 1'b1;
                    fl_pend = 1'b0;
                end
            end
            if (spur_req != spur_ack) begin
                bus.fill_done = 1'b1;
                spur_ack = spur_req;
            end
        end
        ctrl_prev = bus.ctrl_start;
        gs_prev   = bus.gs_start;
        freq_prev = bus.fill_req;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    function automatic int stat(input int v);
`ifdef LED_SLICE_SCHED_STATS_EN
        return v;
`else
        return 0 * v;
`endif
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(negedge TESTCLK);
        #1;
    endtask

    task automatic model_complete();
        if (sh_en) m_busy = 1'b0;
        if (fl_en && m_pend) begin
            m_ready = 1'b1;
            m_pend  = 1'b0;
        end
    endtask

    task automatic model_event(input int op);
        bit ev = 1'b0;
        if (op != 0) begin
            m_tick = 0; m_target = 0; ev = 1'b1;
        end else if (m_tick == T - 1) begin
            m_tick = 0; m_target = (m_target + 1) % N; ev = 1'b1;
        end else begin
            m_tick++;
        end
        if (ev) begin
            if (m_busy) begin
                if (m_over < 16'hFFFF) m_over++;
            end else begin
                m_busy = 1'b1;
                m_gs++;
                if (m_ready) begin
                    m_buf   = 1 - m_buf;
                    m_slice = m_target;
                    m_ready = 1'b0;
                    m_pend  = 1'b1;
                    m_fs    = (m_target + 1) % N;
                end else if (m_under < 16'hFFFF) begin
                    m_under++;
                end
            end
        end
    endtask

    task automatic step(input int op, input bit f, input bit s);
        fl_en = f;
        sh_en = s;
        cyc(10);
        model_complete();
        if (op == 0 || op == 2) enc_tick = 1'b1;
        if (op != 0) enc_home = 1'b1;
        cyc(3);
        enc_tick = 1'b0;
        enc_home = 1'b0;
        model_event(op);
        cyc(13);
        model_complete();
    endtask

    task automatic cmp_model(input string tag);
        chk({tag, "_slice"}, slice_idx, m_slice);
        chk({tag, "_buf"}, bus.buf_sel, m_buf);
        chk({tag, "_fill_slice"}, bus.fill_slice, m_fs);
        chk({tag, "_under"}, underrun_cnt, stat(m_under));
        chk({tag, "_over"}, overrun_cnt, stat(m_over));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: no finish after %0d checks", n_checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k;
        int ctrl_before;
        tbl[0]  = '{0, 1, 1, 0, 1, 0, 0, 1};
        tbl[1]  = '{0, 1, 1, 0, 1, 0, 0, 1};
        tbl[2]  = '{0, 0, 1, 1, 0, 0, 0, 2};
        tbl[3]  = '{0, 0, 1, 1, 0, 0, 0, 2};
        tbl[4]  = '{0, 0, 1, 1, 0, 0, 0, 2};
        tbl[5]  = '{0, 0, 1, 1, 0, 1, 0, 2};
        tbl[6]  = '{0, 1, 0, 1, 0, 1, 0, 2};
        tbl[7]  = '{0, 1, 0, 1, 0, 1, 0, 2};
        tbl[8]  = '{0, 1, 0, 3, 1, 1, 0, 4};
        tbl[9]  = '{0, 1, 0, 3, 1, 1, 0, 4};
        tbl[10] = '{0, 1, 0, 3, 1, 1, 0, 4};
        tbl[11] = '{0, 1, 0, 3, 1, 1, 1, 4};
        tbl[12] = '{0, 1, 0, 3, 1, 1, 1, 4};
        tbl[13] = '{0, 1, 0, 3, 1, 1, 1, 4};
        tbl[14] = '{0, 1, 0, 3, 1, 1, 2, 4};
        tbl[15] = '{0, 1, 1, 3, 1, 1, 2, 4};
        tbl[16] = '{0, 1, 1, 3, 1, 1, 2, 4};
        tbl[17] = '{0, 1, 1, 6, 0, 1, 2, 7};
        tbl[18] = '{2, 1, 1, 0, 1, 1, 2, 1};
        tbl[19] = '{0, 1, 1, 0, 1, 1, 2, 1};
        tbl[20] = '{0, 1, 1, 0, 1, 1, 2, 1};
        tbl[21] = '{0, 1, 1, 1, 0, 1, 2, 2};

        // reset values
        cyc(3);
        chk("rst_ctrl_start", bus.ctrl_start, 0);
        chk("rst_gs_start", bus.gs_start, 0);
        chk("rst_fill_req", bus.fill_req, 0);
        chk("rst_buf_sel", bus.buf_sel, 0);
        chk("rst_fill_slice", bus.fill_slice, 0);
        chk("rst_slice_idx", slice_idx, 0);
        chk("rst_overrun", overrun_cnt, 0);
        chk("rst_underrun", underrun_cnt, 0);
        chk("rst_state", state_dbg, 0);

        // control-latch load, shift_done 20 cycles after ctrl_start
        sh_delay = 20; sh_en = 1'b1; fl_en = 1'b0;
        Reset = 1'b0;
        cyc(1);
        chk("init_state", state_dbg, 1);
        chk("init_ctrl_start", bus.ctrl_start, 1);
        k = 0;
        while (k < 40 && !bus.fill_req) begin
            cyc(1);
            k++;
        end
        chk("init_fill_req_latency", k, 21);
        chk("init_fill_slice", bus.fill_slice, 0);
        chk("init_state_wait_home", state_dbg, 2);
        chk("init_ctrl_count", n_ctrl, 1);

        // ticks are ignored before the first home
        enc_tick = 1'b1; cyc(3); enc_tick = 1'b0; cyc(12);
        chk("wait_home_state", state_dbg, 2);
        chk("wait_home_no_gs", n_gs, 0);

        // home edge after a completed fill: cycle-exact swap
        sh_delay = 3; fl_en = 1'b1;
        cyc(10);
        enc_home = 1'b1;
        cyc(3);
        chk("home_c3_buf", bus.buf_sel, 0);
        chk("home_c3_gs", bus.gs_start, 0);
        enc_home = 1'b0;
        cyc(1);
        chk("home_c4_buf", bus.buf_sel, 1);
        chk("home_c4_slice", slice_idx, 0);
        chk("home_c4_fill_req", bus.fill_req, 1);
        chk("home_c4_fill_slice", bus.fill_slice, 1);
        chk("home_c4_gs", bus.gs_start, 0);
        cyc(1);
        chk("home_c5_gs", bus.gs_start, 1);
        chk("home_c5_fill_req", bus.fill_req, 0);
        cyc(14);

        m_target = 0; m_tick = 0; m_slice = 0; m_buf = 1; m_fs = 1;
        m_under = 0; m_over = 0; m_gs = 1;
        m_ready = 1'b0; m_pend = 1'b1; m_busy = 1'b1;
        model_complete();

        // directed table: underrun, overruns, simultaneous home+tick
        for (int i = 0; i < 22; i++) begin
            step(tbl[i].op, tbl[i].f, tbl[i].s);
            chk($sformatf("tbl%0d_slice", i), slice_idx, tbl[i].slice);
            chk($sformatf("tbl%0d_buf", i), bus.buf_sel, tbl[i].bsel);
            chk($sformatf("tbl%0d_fill_slice", i), bus.fill_slice, tbl[i].fs);
            chk($sformatf("tbl%0d_under", i), underrun_cnt, stat(tbl[i].under));
            chk($sformatf("tbl%0d_over", i), overrun_cnt, stat(tbl[i].over));
        end

        // randomized traffic against the model
        for (int i = 0; i < 300; i++) begin
            int op;
            op = ($urandom_range(0, 19) == 0) ? int'($urandom_range(1, 2)) : 0;
            step(op, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
            cmp_model($sformatf("rnd%0d", i));
        end

        // one full revolution from home with prompt fills and shifts
        step(1, 1'b1, 1'b1);
        cmp_model("rev_home");
        for (int i = 0; i < 3 * N; i++) begin
            step(0, 1'b1, 1'b1);
            if (i % T == T - 1) cmp_model($sformatf("rev%0d", i));
        end
        chk("rev_wrap_slice", slice_idx, 0);

        // mid-operation reset, spurious fill_done during control load
        Reset = 1'b1;
        cyc(2);
        chk("rst2_state", state_dbg, 0);
        chk("rst2_buf", bus.buf_sel, 0);
        chk("rst2_slice", slice_idx, 0);
        chk("rst2_under", underrun_cnt, 0);
        chk("rst2_over", overrun_cnt, 0);
        ctrl_before = n_ctrl;
        sh_delay = 8; sh_en = 1'b1; fl_en = 1'b0;
        Reset = 1'b0;
        cyc(2);
        spur_req++;
        k = 0;
        while (k < 40 && !bus.fill_req) begin
            cyc(1);
            k++;
        end
        chk("rst2_fill_req_seen", bus.fill_req, 1);
        chk("rst2_ctrl_count", n_ctrl - ctrl_before, 1);
        sh_delay = 3;
        cyc(5);
        m_target = 0; m_tick = 0; m_slice = 0; m_buf = 0; m_fs = 0;
        m_under = 0; m_over = 0;
        m_ready = 1'b0; m_pend = 1'b1; m_busy = 1'b0;
        step(1, 1'b0, 1'b1);
        cmp_model("rst2_home");

        chk("pulse_width", n_wide, 0);
        chk("gs_count", n_gs, m_gs);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
